f0_pass_engine: RTL and testbench
=================================

Name: f0_pass_engine

Overview:
- Worker side of the forward-pass handshake.
- Starts a single-layer forward pass when the sequencer raises its f0 pass level, and computes N_OUT dot products of N_IN signed inputs.
- Each result goes through ReLU and saturation, then is written to the activation buffer.
- Returns a one-cycle end pulse that drives the sequencer's f0 end input.
- Sits between the pass sequencer and the input/weight/activation memories.

Parameters:
- DATA_W, 8, signed width of inputs, weights and written activations.
- ACC_W, 20, signed accumulator width; must be >= 2*DATA_W.
- N_IN, 4, inputs per neuron (>=1).
- N_OUT, 4, neurons per layer (>=1).
- X_AW, 2, input address width, clog2(N_IN) (min 1).
- W_AW, 4, weight address width, clog2(N_IN*N_OUT) (min 1).
- Y_AW, 2, output address width, clog2(N_OUT) (min 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  global enable; low freezes all state.
- pass_i  in  1  f0 pass level from sequencer.
- x_addr_o  out  X_AW  input memory read address.
- x_data_i  in  DATA_W  input read data, 1-cycle latency.
- w_addr_o  out  W_AW  weight read address = out_idx*N_IN + in_idx.
- w_data_i  in  DATA_W  weight read data, 1-cycle latency.
- wr_en_o  out  1  activation write strobe.
- wr_addr_o  out  Y_AW  activation write address.
- wr_data_o  out  DATA_W  activation write data.
- busy_o  out  1  high from FETCH through DONE inclusive.
- end_o  out  1  one-cycle pass-complete pulse to sequencer.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. Reset (and reset asserted mid-run) gives:
  - state=IDLE; in_idx, out_idx and acc all 0.
  - Every output 0. No partial write is issued.
- Enable: en_i=0 holds state, counters and acc. wr_en_o and end_o are forced 0 while en_i=0. Addresses hold, so read data must stay valid across the stall.
- States and transitions (all conditioned on en_i=1):
  - IDLE: pass_i=1 -> FETCH.
  - FETCH: x_addr_o=in_idx and w_addr_o=out_idx*N_IN+in_idx are driven combinationally from the counters. Next state MAC.
  - MAC: acc <= acc + sext(x_data_i*w_data_i).
    - Product is signed, 2*DATA_W bits. Accumulation wraps modulo 2^ACC_W.
    - in_idx==N_IN-1 -> WRITE; otherwise in_idx++ and -> FETCH.
  - WRITE: wr_en_o=1, wr_addr_o=out_idx, wr_data_o=sat(acc). Then acc<=0 and in_idx<=0.
    - out_idx==N_OUT-1 -> DONE with out_idx<=0; otherwise out_idx++ and -> FETCH.
  - DONE: end_o=1 for exactly one cycle. Next state HOLD.
  - HOLD: waits for pass_i=0, then -> IDLE. This blocks retrigger while the sequencer still holds the pass level.
- sat(acc):
  - acc<0 -> 0.
  - acc>2^(DATA_W-1)-1 -> 2^(DATA_W-1)-1.
  - Otherwise acc[DATA_W-1:0].
- Latency with en_i constantly 1:
  - First FETCH is the cycle after pass_i is sampled high in IDLE.
  - Each neuron takes 2*N_IN+1 cycles.
  - end_o asserts N_OUT*(2*N_IN+1)+1 cycles after IDLE exit; 37 cycles at defaults.
- Boundary cases:
  - pass_i dropping mid-run is ignored; the run completes and end_o still pulses.
  - pass_i already 0 in DONE: HOLD exits to IDLE on the next cycle.
  - N_IN=1 or N_OUT=1 are legal.
  - wr_en_o and end_o are never high in the same cycle.

Test Plan:
- Basic pass, defaults: x={1,2,3,4}, all weights 1, pass_i held high.
  - Required: four writes of 10 to addresses 0..3.
  - end_o pulses once, 37 cycles after IDLE exit; busy_o then low.
- Saturation and ReLU:
  - Neuron 0: x=127, w=127 everywhere -> acc=64516, write 127.
  - Neuron 1: w=-128, x=127 -> write 0.
- Enable stall: en_i=0 for 5 cycles in the middle of MAC.
  - Required: results identical to the basic pass; end_o delayed by exactly 5 cycles.
  - No wr_en_o during the stall.
- Handshake: pass_i held high for 10 cycles after end_o.
  - Required: no second run, busy_o stays 0.
  - Dropping then re-raising pass_i starts a new run with acc=0.
- Reset mid-run: rst_i=1 during neuron 2.
  - Required: all outputs 0 the next cycle, no further writes.
  - A new pass then produces correct results from address 0.
- Early pass drop: pass_i low after 3 cycles.
  - Required: all 4 writes still occur and end_o pulses once.

Source files
------------

// File: rtl/f0_pass_engine.sv
// Worker side of the f0 forward-pass handshake: N_OUT ReLU/saturated dot products
// of N_IN signed inputs, written to the activation buffer, then a one-cycle end pulse.
module f0_pass_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int X_AW   = 2,
  parameter int W_AW   = 4,
  parameter int Y_AW   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              pass_i,
  output logic [X_AW-1:0]   x_addr_o,
  input  logic [DATA_W-1:0] x_data_i,
  output logic [W_AW-1:0]   w_addr_o,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              wr_en_o,
  output logic [Y_AW-1:0]   wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              end_o
);

  typedef enum logic [2:0] {IDLE, FETCH, MAC, WRITE, DONE, HOLD} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);

  state_t                     state_q, state_d;
  logic        [X_AW-1:0]     in_idx;
  logic        [Y_AW-1:0]     out_idx;
  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic        [DATA_W-1:0]   sat_val;
  logic                       last_in, last_out;

  assign last_in  = (in_idx == X_AW'(N_IN - 1));
  assign last_out = (out_idx == Y_AW'(N_OUT - 1));
  assign prod     = $signed(x_data_i) * $signed(w_data_i);
  assign prod_ext = ACC_W'($signed(prod));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pass_i) state_d = FETCH;
      FETCH:   state_d = MAC;
      MAC:     state_d = last_in ? WRITE : FETCH;
      WRITE:   state_d = last_out ? DONE : FETCH;
      DONE:    state_d = HOLD;
      HOLD:    if (!pass_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!en_i) state_d = state_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      in_idx  <= '0;
      out_idx <= '0;
      acc     <= '0;
    end else if (en_i) begin
      state_q <= state_d;
      case (state_q)
        MAC: begin
          acc <= acc + prod_ext;
          if (!last_in) in_idx <= in_idx + X_AW'(1);
        end
        WRITE: begin
          acc     <= '0;
          in_idx  <= '0;
          out_idx <= last_out ? '0 : out_idx + Y_AW'(1);
        end
        default: ;
      endcase
    end
  end

  // ReLU then clamp to the largest positive DATA_W value
  always_comb begin
    sat_val = acc[DATA_W-1:0];
    if (acc[ACC_W-1])        sat_val = '0;
    else if (acc > SAT_MAX)  sat_val = SAT_MAX[DATA_W-1:0];
  end

  assign x_addr_o  = in_idx;
  assign w_addr_o  = W_AW'(out_idx) * W_AW'(N_IN) + W_AW'(in_idx);
  assign wr_en_o   = en_i && (state_q == WRITE);
  assign wr_addr_o = wr_en_o ? out_idx : '0;
  assign wr_data_o = wr_en_o ? sat_val : '0;
  assign busy_o    = (state_q == FETCH) || (state_q == MAC) ||
                     (state_q == WRITE) || (state_q == DONE);
  assign end_o     = en_i && (state_q == DONE);

endmodule

// File: tb/tb_f0_pass_engine.sv
// Directed bench for f0_pass_engine: table of full-pass vectors plus
// hand-written stall, handshake, mid-run reset and early pass-drop sequences.
module tb_f0_pass_engine;

  logic       clk = 1'b0;
  logic       rst, en, pass;
  logic [1:0] x_addr;
  logic [3:0] w_addr;
  logic [7:0] x_data, w_data;
  logic       wr_en, busy, end_p;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;

  f0_pass_engine #(
    .DATA_W(8), .ACC_W(20), .N_IN(4), .N_OUT(4), .X_AW(2), .W_AW(4), .Y_AW(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pass_i(pass),
    .x_addr_o(x_addr), .x_data_i(x_data),
    .w_addr_o(w_addr), .w_data_i(w_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .end_o(end_p)
  );

  // Registered-read memories: one cycle of read latency
  logic [7:0] xmem [4];
  logic [7:0] wmem [16];
  always @(posedge clk) begin
    x_data <= xmem[x_addr];
    w_data <= wmem[w_addr];
  end

  typedef struct {
    logic [31:0]  x;
    logic [127:0] w;
    logic [31:0]  y;
  } vec_t;
  vec_t tv [4];

  int tests = 0, failed = 0;
  int wr_cnt = 0, end_cnt = 0;
  logic [1:0] wa [8];
  logic [7:0] wd [8];
  bit overlap = 0, stall_bad = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 8) begin
        wa[wr_cnt] = wr_addr;
        wd[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (end_p) end_cnt++;
    if (wr_en && end_p) overlap = 1;
    if ((wr_en || end_p) && !en) stall_bad = 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input int vi);
    for (int i = 0; i < 4; i++)  xmem[i] = tv[vi].x[8*i +: 8];
    for (int i = 0; i < 16; i++) wmem[i] = tv[vi].w[8*i +: 8];
  endtask

  // Raise pass, run to the end pulse, then check latency and the written results.
  task automatic run_pass(input int vi, input int stall_at, input int stall_len,
                          input int drop_at, input int exp_lat);
    int  n = 0;
    bit  done = 0;
    logic [7:0] ey;
    load(vi);
    wr_cnt  = 0;
    end_cnt = 0;
    pass    = 1'b1;
    while (!done && n < 300) begin
      step();
      n++;
      if (end_p) done = 1;
      else begin
        en = !(n >= stall_at && n < stall_at + stall_len);
        if (n == drop_at) pass = 1'b0;
      end
    end
    en = 1'b1;
    check($sformatf("v%0d end_seen", vi), done, 1);
    check($sformatf("v%0d end_latency", vi), n, exp_lat);
    step();
    check($sformatf("v%0d busy_after", vi), busy, 0);
    check($sformatf("v%0d end_count", vi), end_cnt, 1);
    check($sformatf("v%0d write_count", vi), wr_cnt, 4);
    for (int k = 0; k < 4; k++) begin
      ey = tv[vi].y[8*k +: 8];
      check($sformatf("v%0d wr_addr[%0d]", vi, k), wa[k], k);
      check($sformatf("v%0d wr_data[%0d]", vi, k), wd[k], ey);
    end
  endtask

  initial begin
    int  base;
    bit  busy_seen;
    // Basic: every neuron sums 1+2+3+4
    tv[0].x = {8'd4, 8'd3, 8'd2, 8'd1};
    tv[0].w = {16{8'd1}};
    tv[0].y = {8'd10, 8'd10, 8'd10, 8'd10};
    // Saturation/ReLU: 4*127*127=64516 -> 127, -65024 -> 0, 127 -> 127, 254 -> 127
    tv[1].x = {4{8'd127}};
    tv[1].w = {8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
               {4{8'h80}}, {4{8'h7F}}};
    tv[1].y = {8'd127, 8'd127, 8'd0, 8'd127};
    // Mixed signs: 7, -1 -> 0, 80, 52
    tv[2].x = {8'h01, 8'h05, 8'hFE, 8'h03};
    tv[2].w = {8'h07, 8'h04, 8'hEC, 8'hFB, 8'h00, 8'h0A, 8'h00, 8'h0A,
               8'h04, 8'hFF, 8'h03, 8'h02, 8'h01, 8'h01, 8'h01, 8'h01};
    tv[2].y = {8'd52, 8'd80, 8'd0, 8'd7};
    // Clamp boundary: 128 -> 127, 127 -> 127, -64 -> 0, 128 -> 127
    tv[3].x = {8'h00, 8'h00, 8'hFF, 8'h40};
    tv[3].w = {8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF,
               8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02};
    tv[3].y = {8'd127, 8'd0, 8'd127, 8'd127};

    rst = 1'b1; en = 1'b1; pass = 1'b0;
    load(0);
    step(); step();
    rst = 1'b0;
    check("reset outputs", {wr_en, wr_addr, wr_data, busy, end_p, x_addr, w_addr}, 0);

    for (int vi = 0; vi < 4; vi++) begin
      run_pass(vi, 0, 0, -1, 37);
      pass = 1'b0;
      step();
    end

    // Enable stall of 5 cycles inside the first MAC
    run_pass(0, 2, 5, -1, 42);
    pass = 1'b0;
    step();

    // Pass held high after end: no retrigger
    run_pass(0, 0, 0, -1, 37);
    busy_seen = 0;
    repeat (10) begin
      step();
      if (busy) busy_seen = 1;
    end
    check("hold busy", busy_seen, 0);
    check("hold no writes", wr_cnt, 4);
    pass = 1'b0;
    step();
    run_pass(2, 0, 0, -1, 37);
    pass = 1'b0;
    step();

    // Reset during neuron 2
    load(0);
    wr_cnt = 0;
    pass = 1'b1;
    repeat (21) step();
    check("pre-reset writes", wr_cnt, 2);
    rst = 1'b1;
    step();
    check("midrun reset outputs", {wr_en, wr_addr, wr_data, busy, end_p, x_addr, w_addr}, 0);
    rst = 1'b0;
    pass = 1'b0;
    base = wr_cnt;
    repeat (5) step();
    check("post-reset no writes", wr_cnt, base);
    run_pass(0, 0, 0, -1, 37);
    pass = 1'b0;
    step();

    // Pass dropped after 3 cycles; HOLD then exits at once, so a re-raise starts immediately
    run_pass(3, 0, 0, 3, 37);
    step();
    run_pass(1, 0, 0, -1, 37);
    pass = 1'b0;
    step();

    check("wr_en/end_o overlap", overlap, 0);
    check("strobe while disabled", stall_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
